// File: rtl/roi_pkg.sv
// roi_pkg: shared constants, packer state encoding and skid entry layout for roi_pack
// Contents:
//   BIT_D_DEF, LANES_DEF - default pixel width and lane count
//   pack_state_t         - packer FSM states (FILL collecting lanes, HOLD closed word parked)
//   skid_entry_t         - skid buffer entry {data, keep, last} at default widths
//   entry_width()        - entry width for any BIT_D/LANES pair
package roi_pkg;

    localparam int BIT_D_DEF = 8;
    localparam int LANES_DEF = 4;

    typedef enum logic {FILL, HOLD} pack_state_t;

    typedef struct packed {
        logic [BIT_D_DEF*LANES_DEF-1:0] data;
        logic [LANES_DEF-1:0]           keep;
        logic                           last;
    } skid_entry_t;

    function automatic int entry_width(input int bit_d, input int lanes);
        return bit_d * lanes + lanes + 1;
    endfunction

endpackage

// File: rtl/roi_axis_skid.sv
// roi_axis_skid: two-entry output buffer decoupling the packer from downstream backpressure
// Ports:
//   clk_i, arst_i - clock, asynchronous active-high reset
//   i_push        - write i_data this cycle (caller only pushes when o_space is set)
//   i_data        - entry to store
//   o_space       - a slot is free now or frees this cycle through a pop
//   o_valid       - head entry present
//   o_data        - head entry, held until popped
//   i_ready       - downstream accepts head entry
module roi_axis_skid #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_space,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign o_valid = r_cnt != 2'd0;
    assign w_pop   = o_valid && i_ready;
    assign o_space = r_cnt != 2'd2 || w_pop;
    assign o_data  = r_mem[r_rd];

    // A push into a full buffer lands on the head slot, which is leaving in the same cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            r_cnt <= r_cnt + 2'(i_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/roi_pack.sv
// roi_pack: packs a stream of ROI pixels into LANES-wide words with keep mask and frame last
// Ports:
//   clk_i, arst_i            - clock, asynchronous active-high reset
//   s_tdata_i/s_tvalid_i/s_tlast_i/s_tready_o - pixel input stream
//   m_tdata_o/m_tkeep_o/m_tvalid_o/m_tlast_o/m_tready_i - packed word output stream
//   word_cnt_o, frame_cnt_o  - handed-off word and frame counters (only with ROI_PACK_STAT_EN)
// Build option: define ROI_PACK_STAT_EN to add the statistics counters.
module roi_pack
    import roi_pkg::*;
#(
    parameter int BIT_D = BIT_D_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [BIT_D-1:0]       s_tdata_i,
    input  logic                   s_tvalid_i,
    input  logic                   s_tlast_i,
    output logic                   s_tready_o,
    output logic [BIT_D*LANES-1:0] m_tdata_o,
    output logic [LANES-1:0]       m_tkeep_o,
    output logic                   m_tvalid_o,
    output logic                   m_tlast_o,
`ifdef ROI_PACK_STAT_EN
    output logic [31:0]            word_cnt_o,
    output logic [15:0]            frame_cnt_o,
`endif
    input  logic                   m_tready_i
);

    localparam int LW = $clog2(LANES);
    localparam int DW = BIT_D * LANES;
    localparam int EW = entry_width(BIT_D, LANES);

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] keep;
        logic             last;
    } entry_t;

    pack_state_t      r_state;
    logic             r_s_tready;
    logic [LW-1:0]    r_lane;
    logic [DW-1:0]    r_data;
    logic [LANES-1:0] r_keep;
    entry_t           r_hold;

    entry_t           w_word;
    entry_t           w_push_entry;
    entry_t           w_out_entry;
    logic             w_accept;
    logic             w_close;
    logic             w_push;
    logic             w_space;

    assign s_tready_o = r_s_tready;
    assign w_accept   = s_tvalid_i && r_s_tready;
    assign w_close    = w_accept && (r_lane == LW'(LANES - 1) || s_tlast_i);

    // Word as it looks with the current pixel merged in; unfilled lanes stay zero.
    always_comb begin
        w_word      = '{data: r_data, keep: r_keep | (LANES'(1) << r_lane), last: s_tlast_i};
        w_word.data[r_lane*BIT_D +: BIT_D] = s_tdata_i;
    end

    assign w_push       = (r_state == HOLD) ? w_space : (w_close && w_space);
    assign w_push_entry = (r_state == HOLD) ? r_hold : w_word;

    // s_tready_o is registered: it only reflects the next FSM state, never m_tready_i directly.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= FILL;
            r_s_tready <= 1'b0;
            r_lane     <= '0;
            r_data     <= '0;
            r_keep     <= '0;
            r_hold     <= '0;
        end else begin
            if (w_accept) begin
                r_lane <= w_close ? '0 : r_lane + LW'(1);
                r_data <= w_close ? '0 : w_word.data;
                r_keep <= w_close ? '0 : w_word.keep;
            end
            case (r_state)
                FILL: begin
                    if (w_close && !w_space) begin
                        r_state    <= HOLD;
                        r_hold     <= w_word;
                        r_s_tready <= 1'b0;
                    end else begin
                        r_s_tready <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_space) begin
                        r_state    <= FILL;
                        r_s_tready <= 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    roi_axis_skid #(.W(EW)) u_skid (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .o_space (w_space),
        .o_valid (m_tvalid_o),
        .o_data  (w_out_entry),
        .i_ready (m_tready_i)
    );

    assign m_tdata_o = w_out_entry.data;
    assign m_tkeep_o = w_out_entry.keep;
    assign m_tlast_o = w_out_entry.last;

`ifdef ROI_PACK_STAT_EN
    logic [31:0] r_word_cnt;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (m_tvalid_o && m_tready_i) begin
            r_word_cnt  <= r_word_cnt + 32'd1;
            r_frame_cnt <= m_tlast_o ? r_frame_cnt + 16'd1 : r_frame_cnt;
        end
    end

    assign word_cnt_o  = r_word_cnt;
    assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: doc/roi_pack.md
ROI_PACK -- requirements
Module: roi_pack

Interface
REQ-001 SHALL have parameter BIT_D, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning pixels per output word (power of two, 2..8).
REQ-003 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port arst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_tdata_i  input  BIT_D  ROI pixel from upstream crop stage.
REQ-006 SHALL have port s_tvalid_i  input  1  pixel valid.
REQ-007 SHALL have port s_tlast_i  input  1  last pixel of ROI frame.
REQ-008 SHALL have port s_tready_o  output  1  block can accept a pixel.
REQ-009 SHALL have port m_tdata_o  output  BIT_D*LANES  packed word.
REQ-010 SHALL have port m_tkeep_o  output  LANES  per-lane valid mask.
REQ-011 SHALL have port m_tvalid_o  output  1  word valid.
REQ-012 SHALL have port m_tlast_o  output  1  last word of ROI frame.
REQ-013 SHALL have port m_tready_i  input  1  downstream accepts word.

Function
REQ-014 A pixel SHALL be accepted only on a cycle with s_tvalid_i && s_tready_o.
REQ-015 Accepted pixels SHALL fill lanes little-endian: first pixel of a word in bits [BIT_D-1:0], lane index k in bits [k*BIT_D +: BIT_D].
REQ-016 A word SHALL close when lane LANES-1 is filled or when the accepted pixel has s_tlast_i=1.
REQ-017 Closed word SHALL carry m_tkeep_o bit k = 1 for every filled lane, 0 otherwise; unfilled lane data SHALL be 0.
REQ-018 m_tlast_o SHALL be 1 only on a word closed by s_tlast_i; lane counter SHALL return to 0 after it.
REQ-019 Packer FSM states: FILL (collecting lanes), HOLD (closed word waiting for buffer space); FILL->HOLD when word closes and buffer full; HOLD->FILL when buffer space frees; in HOLD s_tready_o=0.
REQ-020 Output SHALL pass through a 2-entry skid buffer; s_tready_o SHALL depend only on registered state (no combinational path from m_tready_i).
REQ-021 Latency: with empty buffer and m_tready_i=1, word SHALL appear on m_tvalid_o the cycle after the closing pixel is accepted.
REQ-022 While m_tvalid_o && !m_tready_i, m_tdata_o, m_tkeep_o, m_tlast_o SHALL remain stable.
REQ-023 Sustained throughput SHALL be one pixel per cycle with m_tready_i held 1; no pixel SHALL be lost or duplicated under any backpressure pattern.
REQ-024 Word close and buffer pop in the same cycle SHALL both take effect (no HOLD entry if a slot frees that cycle).
REQ-025 s_tlast_i with no s_tvalid_i SHALL be ignored.

Reset
REQ-026 On arst_i: m_tvalid_o=0, m_tlast_o=0, m_tkeep_o=0, m_tdata_o=0, s_tready_o=0 during reset and 1 from first cycle after release, FSM=FILL, lane counter 0, buffer empty.
REQ-027 Reset mid-word SHALL discard the partial word and all buffered words.

Configuration
REQ-028 Macro ROI_PACK_STAT_EN, when defined, SHALL add outputs word_cnt_o (output, 32, words handed off, wraps) and frame_cnt_o (output, 16, m_tlast_o handoffs, wraps), both reset to 0, incremented on m_tvalid_o && m_tready_i.
REQ-029 Without ROI_PACK_STAT_EN those ports and counters SHALL not exist; remaining behaviour identical.

Structure
REQ-030 Package roi_pkg SHALL hold BIT_D default constant, pack state enum (FILL, HOLD) and skid-entry struct (data, keep, last).
REQ-031 Skid buffer SHALL be sub-module roi_axis_skid, parameterised on entry width.

Verification
REQ-032 Pixels 0x01..0x08 no tlast, m_tready_i=1 -> words 0x04030201, 0x08070605, keep 0xF, tlast 0.
REQ-033 Pixels 0xA0,0xA1,0xA2 with tlast on 0xA2 -> word 0x00A2A1A0, keep 0x7, tlast 1.
REQ-034 Single pixel 0x55 with tlast -> word 0x00000055, keep 0x1, tlast 1; next word starts at lane 0.
REQ-035 m_tready_i=0 for 20 cycles during 16-pixel burst -> s_tready_o drops within 12 accepted pixels, output held stable, all 4 words delivered in order after release.
REQ-036 Random m_tready_i, 1000 random pixels, random tlast -> scoreboard exact match; with ROI_PACK_STAT_EN counts equal words/frames sent.
REQ-037 arst_i pulsed after 2 pixels of a word -> no output from them; next 4 pixels form keep 0xF word.
